// File: rtl/miner_pkg.sv
// rtl/miner_pkg.sv - shared constants and FSM state type for the golden-nonce reporting path
package miner_pkg;

    localparam int NONCE_W         = 32;
    localparam int BYTES_PER_NONCE = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } report_state_t;

endpackage

// File: rtl/nonce_fifo.sv
// rtl/nonce_fifo.sv - single-clock synchronous FIFO with push+pop allowed while full
// Ports: clk, reset (sync, active-high); push/push_data write side;
// pop/pop_data read side (pop_data shows the head combinationally);
// full, empty, count status from registered state.
module nonce_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_ok   = pop && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/golden_nonce_reporter.sv
// rtl/golden_nonce_reporter.sv - buffers golden-nonce strobes and frames each as 4 bytes, LSB first
// Ports: clk, reset (sync, active-high); nonce_valid/nonce_in strobe from the hashers;
// tx_valid/tx_data/tx_ready byte handshake to the UART transmitter;
// busy, fifo_count, overflow (sticky), drop_count (saturating) status.
// Build option: NONCE_ADJUST_EN stores (nonce_in - NONCE_OFFSET) through an extra register stage.
module golden_nonce_reporter #(
    parameter int          FIFO_DEPTH   = 4,
    parameter int          NONCE_W      = 32,
    parameter logic [31:0] NONCE_OFFSET = 32'd0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          nonce_valid,
    input  logic [NONCE_W-1:0]            nonce_in,
    output logic                          tx_valid,
    output logic [7:0]                    tx_data,
    input  logic                          tx_ready,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [7:0]                    drop_count
);

    import miner_pkg::*;

    report_state_t        state;
    report_state_t        state_next;
    logic                 push_valid;
    logic [NONCE_W-1:0]   push_data;
    logic [NONCE_W-1:0]   fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    logic                 drop;
    logic [NONCE_W-1:0]   shreg;
    logic [1:0]           byte_idx;
    logic                 last_byte_taken;

`ifdef NONCE_ADJUST_EN
    // Hasher pipelines report a nonce advanced by their depth; undo it here.
    logic                 adj_valid;
    logic [NONCE_W-1:0]   adj_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            adj_valid <= 1'b0;
            adj_data  <= '0;
        end else begin
            adj_valid <= nonce_valid;
            adj_data  <= nonce_in - NONCE_OFFSET;
        end
    end

    assign push_valid = adj_valid;
    assign push_data  = adj_data;
`else
    assign push_valid = nonce_valid;
    assign push_data  = nonce_in;
`endif

    // The FSM only loads from IDLE, so a new entry is never popped in its push cycle.
    assign pop  = (state == IDLE) && !fifo_empty;
    assign drop = push_valid && fifo_full && !pop;

    nonce_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (NONCE_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_valid),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign last_byte_taken = tx_ready && (byte_idx == 2'(BYTES_PER_NONCE - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!fifo_empty)     state_next = SEND;
            SEND:    if (last_byte_taken) state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg      <= '0;
            byte_idx   <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (pop) begin
                shreg    <= fifo_head;
                byte_idx <= '0;
            end else if (state == SEND && tx_ready) begin
                shreg    <= shreg >> 8;
                byte_idx <= byte_idx + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 1'b1;
                end
            end
        end
    end

    // Outputs decode flops only, so they change solely on clock edges.
    always_comb begin
        tx_valid = (state == SEND);
        tx_data  = shreg[7:0];
        busy     = (state != IDLE) || (fifo_count != '0);
    end

endmodule

// File: tb/tb_golden_nonce_reporter.sv
// tb/tb_golden_nonce_reporter.sv - directed table-driven bench for golden_nonce_reporter
module tb_golden_nonce_reporter;

`ifdef NONCE_ADJUST_EN
    localparam logic [31:0] OFFS = 32'd3;
`else
    localparam logic [31:0] OFFS = 32'd0;
`endif

    logic        clk;
    logic        reset;
    logic        nonce_valid;
    logic [31:0] nonce_in;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        busy;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic [7:0]  drop_count;

    int checks;
    int failures;

    typedef struct {
        logic        rst;
        logic        nv;
        logic [31:0] nin;
        logic        rdy;
        logic        tv;
        logic [7:0]  data;
        logic        dchk;
        logic        bsy;
        logic [2:0]  cnt;
        logic        ovf;
        logic [7:0]  drop;
    } vec_t;

    vec_t        rows[$];
    logic [31:0] exp_q[$];

    golden_nonce_reporter #(
        .FIFO_DEPTH   (4),
        .NONCE_W      (32),
        .NONCE_OFFSET (OFFS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .nonce_valid (nonce_valid),
        .nonce_in    (nonce_in),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic void add(input logic rst, input logic nv, input logic [31:0] nin,
                                input logic rdy, input logic tv, input logic [7:0] data,
                                input logic dchk, input logic bsy, input logic [2:0] cnt,
                                input logic ovf, input logic [7:0] drop);
        vec_t r;
        r.rst = rst; r.nv = nv; r.nin = nin; r.rdy = rdy; r.tv = tv; r.data = data;
        r.dchk = dchk; r.bsy = bsy; r.cnt = cnt; r.ovf = ovf; r.drop = drop;
        rows.push_back(r);
    endfunction

    // Drive one row's inputs, compare the registered outputs of this cycle, advance.
    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            reset       = rows[i].rst;
            nonce_valid = rows[i].nv;
            nonce_in    = rows[i].nin;
            tx_ready    = rows[i].rdy;
            chk($sformatf("row%0d_tx_valid", i), 32'(tx_valid), 32'(rows[i].tv));
            if (rows[i].tv || rows[i].dchk)
                chk($sformatf("row%0d_tx_data", i), 32'(tx_data), 32'(rows[i].data));
            chk($sformatf("row%0d_busy", i), 32'(busy), 32'(rows[i].bsy));
            chk($sformatf("row%0d_fifo_count", i), 32'(fifo_count), 32'(rows[i].cnt));
            chk($sformatf("row%0d_overflow", i), 32'(overflow), 32'(rows[i].ovf));
            chk($sformatf("row%0d_drop_count", i), 32'(drop_count), 32'(rows[i].drop));
            step();
        end
        reset       = 1'b0;
        nonce_valid = 1'b0;
    endtask

    // Accept bytes with tx_ready=1 and compare against the nonces queued in exp_q.
    task automatic drain(input string tag);
        int          n;
        int          got;
        logic [31:0] w;
        logic [7:0]  b;
        n   = exp_q.size();
        got = 0;
        tx_ready = 1'b1;
        for (int cyc = 0; cyc < n * 12 + 20 && got < n * 4; cyc++) begin
            if (tx_valid) begin
                w = exp_q[got / 4];
                b = w[8 * (got % 4) +: 8];
                chk($sformatf("%s_byte%0d", tag, got), 32'(tx_data), 32'(b));
                got++;
            end
            step();
        end
        chk($sformatf("%s_byte_total", tag), 32'(got), 32'(n * 4));
        chk($sformatf("%s_idle_valid", tag), 32'(tx_valid), 32'd0);
        chk($sformatf("%s_idle_busy", tag), 32'(busy), 32'd0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        nonce_valid = 1'b0;
        tx_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk("reset_tx_valid", 32'(tx_valid), 32'd0);
        chk("reset_tx_data", 32'(tx_data), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_fifo_count", 32'(fifo_count), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        chk("reset_drop_count", 32'(drop_count), 32'd0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        nonce_valid = 1'b0;
        nonce_in = '0;
        tx_ready = 1'b0;

        // rst nv nonce rdy | tv data dchk busy cnt ovf drop
        // single frame, ready held high: rows 0-6
        add(0, 1, 32'h48750833, 1,  0, 8'h00, 1, 0, 3'd0, 0, 8'd0);
        add(0, 0, 32'h0,        1,  0, 8'h00, 0, 1, 3'd1, 0, 8'd0);
        add(0, 0, 32'h0,        1,  1, 8'h33, 0, 1, 3'd0, 0, 8'd0);
        add(0, 0, 32'h0,        1,  1, 8'h08, 0, 1, 3'd0, 0, 8'd0);
        add(0, 0, 32'h0,        1,  1, 8'h75, 0, 1, 3'd0, 0, 8'd0);
        add(0, 0, 32'h0,        1,  1, 8'h48, 0, 1, 3'd0, 0, 8'd0);
        add(0, 0, 32'h0,        1,  0, 8'h00, 0, 0, 3'd0, 0, 8'd0);
        // six back-to-back strobes, ready low, sixth dropped: rows 7-13
        add(0, 1, 32'h1,        0,  0, 8'h00, 0, 0, 3'd0, 0, 8'd0);
        add(0, 1, 32'h2,        0,  0, 8'h00, 0, 1, 3'd1, 0, 8'd0);
        add(0, 1, 32'h3,        0,  1, 8'h01, 0, 1, 3'd1, 0, 8'd0);
        add(0, 1, 32'h4,        0,  1, 8'h01, 0, 1, 3'd2, 0, 8'd0);
        add(0, 1, 32'h5,        0,  1, 8'h01, 0, 1, 3'd3, 0, 8'd0);
        add(0, 1, 32'h6,        0,  1, 8'h01, 0, 1, 3'd4, 0, 8'd0);
        add(0, 0, 32'h0,        0,  1, 8'h01, 0, 1, 3'd4, 1, 8'd1);
        // reset after two bytes accepted: rows 14-20
        add(0, 1, 32'h48750833, 1,  0, 8'h00, 0, 0, 3'd0, 1, 8'd1);
        add(0, 1, 32'h00000055, 1,  0, 8'h00, 0, 1, 3'd1, 1, 8'd1);
        add(0, 0, 32'h0,        1,  1, 8'h33, 0, 1, 3'd1, 1, 8'd1);
        add(0, 0, 32'h0,        1,  1, 8'h08, 0, 1, 3'd1, 1, 8'd1);
        add(1, 0, 32'h0,        1,  1, 8'h75, 0, 1, 3'd1, 1, 8'd1);
        add(0, 0, 32'h0,        1,  0, 8'h00, 1, 0, 3'd0, 0, 8'd0);
        add(0, 0, 32'h0,        1,  0, 8'h00, 0, 0, 3'd0, 0, 8'd0);
        // push+pop while full: rows 21-31
        add(0, 1, 32'hA1B2C3D4, 0,  0, 8'h00, 0, 0, 3'd0, 0, 8'd0);
        add(0, 1, 32'h0BADF00D, 0,  0, 8'h00, 0, 1, 3'd1, 0, 8'd0);
        add(0, 1, 32'h13572468, 0,  1, 8'hD4, 0, 1, 3'd1, 0, 8'd0);
        add(0, 1, 32'h24681357, 0,  1, 8'hD4, 0, 1, 3'd2, 0, 8'd0);
        add(0, 1, 32'h5A5AA5A5, 0,  1, 8'hD4, 0, 1, 3'd3, 0, 8'd0);
        add(0, 0, 32'h0,        1,  1, 8'hD4, 0, 1, 3'd4, 0, 8'd0);
        add(0, 0, 32'h0,        1,  1, 8'hC3, 0, 1, 3'd4, 0, 8'd0);
        add(0, 0, 32'h0,        1,  1, 8'hB2, 0, 1, 3'd4, 0, 8'd0);
        add(0, 0, 32'h0,        1,  1, 8'hA1, 0, 1, 3'd4, 0, 8'd0);
        add(0, 1, 32'hC0FFEE00, 1,  0, 8'h00, 0, 1, 3'd4, 0, 8'd0);
        add(0, 0, 32'h0,        0,  1, 8'h0D, 0, 1, 3'd4, 0, 8'd0);

        do_reset();

`ifndef NONCE_ADJUST_EN
        run_rows(0, 6);

        // Same nonce with ready 1 cycle on / 3 off.
        begin
            logic [7:0] exp_b [4];
            logic       prev_stall;
            logic [7:0] prev_data;
            int         bcnt;
            exp_b[0] = 8'h33; exp_b[1] = 8'h08; exp_b[2] = 8'h75; exp_b[3] = 8'h48;
            prev_stall = 1'b0;
            prev_data  = '0;
            bcnt       = 0;
            nonce_valid = 1'b1;
            nonce_in    = 32'h48750833;
            tx_ready    = 1'b0;
            step();
            nonce_valid = 1'b0;
            for (int cyc = 0; cyc < 60 && bcnt < 4; cyc++) begin
                tx_ready = (cyc % 4 == 3);
                if (tx_valid && prev_stall)
                    chk($sformatf("stall_hold_c%0d", cyc), 32'(tx_data), 32'(prev_data));
                if (tx_valid && tx_ready) begin
                    chk($sformatf("stall_byte%0d", bcnt), 32'(tx_data), 32'(exp_b[bcnt]));
                    bcnt++;
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
                step();
            end
            chk("stall_byte_total", 32'(bcnt), 32'd4);
            chk("stall_idle_valid", 32'(tx_valid), 32'd0);
            tx_ready = 1'b0;
        end

        run_rows(7, 13);
        exp_q = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
        drain("ovf_drain");

        run_rows(14, 20);
        nonce_valid = 1'b1;
        nonce_in    = 32'hDEADBEEF;
        step();
        nonce_valid = 1'b0;
        exp_q = '{32'hDEADBEEF};
        drain("post_reset");

        do_reset();
        run_rows(21, 31);
        exp_q = '{32'h0BADF00D, 32'h13572468, 32'h24681357, 32'h5A5AA5A5, 32'hC0FFEE00};
        drain("full_pushpop");
        chk("full_pushpop_overflow", 32'(overflow), 32'd0);
        chk("full_pushpop_drops", 32'(drop_count), 32'd0);
`else
        // Offset 3 with one extra pipeline cycle before the FIFO.
        nonce_valid = 1'b1;
        nonce_in    = 32'h30d9db7a;
        tx_ready    = 1'b1;
        step();
        nonce_valid = 1'b0;
        chk("adj_n1_valid", 32'(tx_valid), 32'd0);
        step();
        chk("adj_n2_valid", 32'(tx_valid), 32'd0);
        step();
        chk("adj_n3_valid", 32'(tx_valid), 32'd1);
        chk("adj_n3_data", 32'(tx_data), 32'h77);
        exp_q = '{32'h30d9db77};
        drain("adj_frame");

        nonce_valid = 1'b1;
        nonce_in    = 32'h00000001;
        step();
        nonce_valid = 1'b0;
        exp_q = '{32'hFFFFFFFE};
        drain("adj_wrap");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/golden_nonce_reporter.md
Name: golden_nonce_reporter

Overview:
- Sits directly downstream of the hasher array in fpgaminer_top. Consumes one-cycle golden-nonce strobes and buffers them in a small FIFO, so back-to-back hits from either hasher bank are not lost.
- Serializes each nonce as a 4-byte frame into the UART transmitter's byte interface (valid/ready). Replaces the direct golden_nonce/serial_send coupling.

Parameters:
- FIFO_DEPTH, 4, number of buffered nonces; power of two, 2..16
- NONCE_W, 32, nonce width in bits; fixed 32 for framing; other values are illegal
- NONCE_OFFSET, 32'd0, value subtracted from the nonce when NONCE_ADJUST_EN is defined

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- nonce_valid  in  1  one-cycle strobe: golden nonce found
- nonce_in  in  32  golden nonce, sampled when nonce_valid=1
- tx_valid  out  1  byte available to UART transmitter
- tx_data  out  8  byte to transmit
- tx_ready  in  1  UART transmitter can accept a byte this cycle
- busy  out  1  frame in progress or FIFO non-empty
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries currently queued
- overflow  out  1  sticky: a nonce was dropped because the FIFO was full
- drop_count  out  8  saturating count of dropped nonces

Behaviour:
- Reset (sync, active-high) drives tx_valid=0, tx_data=0, busy=0, fifo_count=0, overflow=0, drop_count=0, FSM=IDLE, FIFO pointers=0. Reset mid-frame aborts the frame; no partial bytes follow.
- FIFO push: nonce_valid=1 and (not full, or a pop in the same cycle) writes nonce_in. Write pointer wraps modulo FIFO_DEPTH.
- Push when full with no pop in that cycle: the new nonce is dropped and the queued entries are kept. overflow<=1 (sticky until reset). drop_count increments and saturates at 255.
- Simultaneous push+pop on empty FIFO: not possible. A pop requires non-empty; the pushed entry becomes visible the next cycle (1-cycle min latency strobe->FSM load).
- FSM states:
  - IDLE: if FIFO non-empty, pop head into a 32-bit shift register, byte_idx<=0, go to SEND. Pop happens in this cycle.
  - SEND: tx_valid=1, tx_data=shreg[7:0]. On tx_valid&tx_ready: shreg>>=8, byte_idx++. If byte_idx==3 go to IDLE, else stay in SEND.
- Byte order: LSB first (nonce 0x48750833 -> 0x33, 0x08, 0x75, 0x48).
- tx_data and tx_valid are registered outputs. tx_data holds its value while tx_valid=1 and tx_ready=0 (no change without acceptance). tx_valid may rise whether or not tx_ready is high.
- Frame gap: at least 1 idle cycle (tx_valid=0) between frames, because IDLE takes one cycle to load.
- Best-case latency: nonce_valid at cycle N -> first byte tx_valid at N+2 with an empty FIFO and the FSM in IDLE. A frame takes 4 accepted handshakes.
- busy = (FSM!=IDLE) | (fifo_count!=0).
- fifo_count reflects the registered state. A push and pop in the same cycle leave it unchanged.

Optional Feature:
- Macro: NONCE_ADJUST_EN.
- Defined: the value written to the FIFO is (nonce_in - NONCE_OFFSET) mod 2^32. The subtractor is registered into the push path, adding +1 cycle to latency (first byte at N+3). Wrap-around is required, e.g. 0x00000001 - 2 = 0xFFFFFFFF. This compensates for the hasher pipeline reporting a nonce advanced by its depth.
- Not defined: nonce_in is stored unmodified, there is no extra cycle, and NONCE_OFFSET is ignored.

Decomposition:
- Shared package miner_pkg holds:
  - NONCE_W = 32
  - BYTES_PER_NONCE = 4
  - FSM state enum report_state_t {IDLE, SEND}
- One sub-module: nonce_fifo, a synchronous FIFO with a single clock and sync reset, parameterized by depth and width. It provides push/pop/full/empty/count and same-cycle push+pop when full.
- The FSM, shift register and counters stay in golden_nonce_reporter.

Test Plan:
- Single nonce 0x48750833, tx_ready held 1 -> tx_valid first high 2 cycles after strobe; bytes 0x33, 0x08, 0x75, 0x48 on 4 consecutive cycles; then tx_valid=0 and busy=0.
- Same nonce, tx_ready toggling 1 cycle on / 3 cycles off -> tx_data stable while stalled; byte sequence unchanged; no byte duplicated or skipped.
- 6 strobes on consecutive cycles (0x00000001..0x00000006), FIFO_DEPTH=4, tx_ready=0 -> first nonce popped into shreg, next 4 queued, 0x00000006 dropped; overflow=1, drop_count=1. After tx_ready=1, frames for 1..5 appear in order.
- Push+pop same cycle with FIFO full -> no drop, overflow stays 0, fifo_count unchanged.
- Reset asserted after byte 2 of a frame -> next cycle tx_valid=0, fifo_count=0, overflow=0. A new nonce 0xDEADBEEF afterwards sends 0xEF, 0xBE, 0xAD, 0xDE.
- NONCE_ADJUST_EN defined, NONCE_OFFSET=3, nonce 0x30d9db7a -> frame bytes 0x77, 0xdb, 0xd9, 0x30, first byte at N+3. Nonce 0x00000001 -> 0xFE, 0xFF, 0xFF, 0xFF.
